// File: rtl/load_ext_pipe.sv
// rtl/load_ext_pipe.sv - load-data lane select and sign/zero extension with a 2-entry skid buffer
module load_ext_pipe #(
  parameter int DATA_WIDTH = 32,
  parameter int BIG_ENDIAN = 1,
  parameter int TAG_WIDTH  = 5,
  localparam int OFS_W     = $clog2(DATA_WIDTH / 8)
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [DATA_WIDTH-1:0] in_data,
  input  logic [OFS_W-1:0]      in_addr,
  input  logic [1:0]            in_size,
  input  logic                  in_sext,
  input  logic [TAG_WIDTH-1:0]  in_tag,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [DATA_WIDTH-1:0] out_data,
  output logic [TAG_WIDTH-1:0]  out_tag,
  output logic                  out_err
);

  // Wide enough to hold DATA_WIDTH itself, so the big-endian shift math cannot wrap on legal accesses.
  localparam int SH_W = $clog2(DATA_WIDTH) + 1;

  logic [SH_W-1:0]       ofs_bits;
  logic [SH_W-1:0]       size_bits;
  logic [SH_W-1:0]       shamt;
  logic [DATA_WIDTH-1:0] shifted;
  logic [DATA_WIDTH-1:0] mask;
  logic [DATA_WIDTH-1:0] ext_data;
  logic                  msb;
  logic                  ext_err;

  // Output register (OR) and skid register (SR) contents.
  logic                  or_valid_q, or_valid_d;
  logic [DATA_WIDTH-1:0] or_data_q, or_data_d;
  logic [TAG_WIDTH-1:0]  or_tag_q, or_tag_d;
  logic                  or_err_q, or_err_d;
  logic                  sr_valid_q, sr_valid_d;
  logic [DATA_WIDTH-1:0] sr_data_q, sr_data_d;
  logic [TAG_WIDTH-1:0]  sr_tag_q, sr_tag_d;
  logic                  sr_err_q, sr_err_d;

  logic accept;
  logic drain;

  // Shift the addressed field down to bit 0, then mask or sign-fill above it; errors force zero data.
  always_comb begin
    ofs_bits  = SH_W'({in_addr, 3'b000});
    size_bits = SH_W'(8) << in_size;
    if (BIG_ENDIAN != 0) begin
      shamt = SH_W'(DATA_WIDTH) - ofs_bits - size_bits;
    end else begin
      shamt = ofs_bits;
    end
    shifted = in_data >> shamt;
    mask    = '1;
    msb     = shifted[DATA_WIDTH-1];
    ext_err = 1'b0;
    case (in_size)
      2'b00: begin
        mask = DATA_WIDTH'(8'hFF);
        msb  = shifted[7];
      end
      2'b01: begin
        mask    = DATA_WIDTH'(16'hFFFF);
        msb     = shifted[15];
        ext_err = in_addr[0];
      end
      2'b10: begin
        mask    = DATA_WIDTH'(32'hFFFF_FFFF);
        msb     = shifted[31];
        ext_err = |in_addr[1:0];
      end
      default: begin
        ext_err = (DATA_WIDTH == 32) || (|in_addr);
      end
    endcase
    // A full-width mask makes sign-fill a no-op, so in_sext is ignored at native width.
    ext_data = (in_sext && msb) ? (shifted | ~mask) : (shifted & mask);
    if (ext_err) begin
      ext_data = '0;
    end
  end

  assign accept = in_valid && !sr_valid_q;
  assign drain  = or_valid_q && out_ready;

  // Skid-buffer next state: SR refills OR on drain, new beats go to OR if it frees up, else to SR.
  always_comb begin
    or_valid_d = or_valid_q;
    or_data_d  = or_data_q;
    or_tag_d   = or_tag_q;
    or_err_d   = or_err_q;
    sr_valid_d = sr_valid_q;
    sr_data_d  = sr_data_q;
    sr_tag_d   = sr_tag_q;
    sr_err_d   = sr_err_q;
    if (drain) begin
      if (sr_valid_q) begin
        or_data_d  = sr_data_q;
        or_tag_d   = sr_tag_q;
        or_err_d   = sr_err_q;
        sr_valid_d = 1'b0;
      end else if (accept) begin
        or_data_d = ext_data;
        or_tag_d  = in_tag;
        or_err_d  = ext_err;
      end else begin
        or_valid_d = 1'b0;
      end
    end else if (accept) begin
      if (!or_valid_q) begin
        or_valid_d = 1'b1;
        or_data_d  = ext_data;
        or_tag_d   = in_tag;
        or_err_d   = ext_err;
      end else begin
        sr_valid_d = 1'b1;
        sr_data_d  = ext_data;
        sr_tag_d   = in_tag;
        sr_err_d   = ext_err;
      end
    end
  end

  // Buffer registers; reset empties both entries and clears the visible result.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      or_valid_q <= 1'b0;
      or_data_q  <= '0;
      or_tag_q   <= '0;
      or_err_q   <= 1'b0;
      sr_valid_q <= 1'b0;
      sr_data_q  <= '0;
      sr_tag_q   <= '0;
      sr_err_q   <= 1'b0;
    end else begin
      or_valid_q <= or_valid_d;
      or_data_q  <= or_data_d;
      or_tag_q   <= or_tag_d;
      or_err_q   <= or_err_d;
      sr_valid_q <= sr_valid_d;
      sr_data_q  <= sr_data_d;
      sr_tag_q   <= sr_tag_d;
      sr_err_q   <= sr_err_d;
    end
  end

  // in_ready depends only on SR occupancy, never on out_ready.
  assign in_ready  = !sr_valid_q;
  assign out_valid = or_valid_q;
  assign out_data  = or_data_q;
  assign out_tag   = or_tag_q;
  assign out_err   = or_err_q;

endmodule

// File: tb/tb_load_ext_pipe.sv
// tb/tb_load_ext_pipe.sv - self-checking bench for load_ext_pipe, big- and little-endian instances
module tb_load_ext_pipe;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid;
  logic        out_ready;
  logic [31:0] in_data;
  logic [1:0]  in_addr;
  logic [1:0]  in_size;
  logic        in_sext;
  logic [4:0]  in_tag;

  logic        in_ready_b, out_valid_b, out_err_b;
  logic [31:0] out_data_b;
  logic [4:0]  out_tag_b;
  logic        in_ready_l, out_valid_l, out_err_l;
  logic [31:0] out_data_l;
  logic [4:0]  out_tag_l;

  typedef struct {
    logic [4:0]  tag;
    logic        err;
    logic [31:0] be;
    logic [31:0] le;
  } exp_t;

  exp_t        sb[$];
  logic [4:0]  popped_tags[$];
  int          n_cmp = 0;
  int          n_bad = 0;
  bit          hold_pending = 1'b0;
  logic [31:0] hold_data;
  logic [4:0]  hold_tag;
  logic        hold_err;

  always #5 clk = ~clk;

  load_ext_pipe #(.DATA_WIDTH(32), .BIG_ENDIAN(1), .TAG_WIDTH(5)) dut_be (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready_b),
    .in_data(in_data), .in_addr(in_addr), .in_size(in_size), .in_sext(in_sext),
    .in_tag(in_tag), .out_valid(out_valid_b), .out_ready(out_ready),
    .out_data(out_data_b), .out_tag(out_tag_b), .out_err(out_err_b)
  );

  load_ext_pipe #(.DATA_WIDTH(32), .BIG_ENDIAN(0), .TAG_WIDTH(5)) dut_le (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready_l),
    .in_data(in_data), .in_addr(in_addr), .in_size(in_size), .in_sext(in_sext),
    .in_tag(in_tag), .out_valid(out_valid_l), .out_ready(out_ready),
    .out_data(out_data_l), .out_tag(out_tag_l), .out_err(out_err_l)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Reference: lay the word out as memory bytes, gather n bytes in significance order, extend arithmetically.
  function automatic logic [32:0] ref_load(input logic [31:0] d, input int a, input int sz,
                                           input bit sx, input bit be);
    int              n;
    logic [7:0]      mem[4];
    longint unsigned v;
    n = 1 << sz;
    if (n > 4 || (a % n) != 0) return {1'b1, 32'h0};
    for (int i = 0; i < 4; i++) mem[i] = be ? d[31-8*i -: 8] : d[8*i +: 8];
    v = 0;
    for (int i = 0; i < n; i++) v = (v << 8) | longint'(be ? mem[a+i] : mem[a+n-1-i]);
    if (sx && v[8*n-1]) v = v - (64'd1 << (8*n));
    return {1'b0, v[31:0]};
  endfunction

  // One cycle: score the transfers the current inputs cause, then advance to 1 time unit after the edge.
  task automatic step(output bit acc);
    exp_t        e;
    logic [32:0] rb, rl;
    if (hold_pending) begin
      check("hold_data", out_data_b, hold_data);
      check("hold_tag", out_tag_b, hold_tag);
      check("hold_err", out_err_b, hold_err);
    end
    hold_pending = out_valid_b && !out_ready;
    hold_data = out_data_b;
    hold_tag  = out_tag_b;
    hold_err  = out_err_b;
    acc = in_valid && in_ready_b;
    if (out_valid_b && out_ready) begin
      if (sb.size() == 0) begin
        check("spurious_out", out_valid_b, 1'b0);
      end else begin
        e = sb.pop_front();
        check("sb_tag", out_tag_b, e.tag);
        check("sb_err", out_err_b, e.err);
        check("sb_data_be", out_data_b, e.be);
        check("sb_data_le", out_data_l, e.le);
        check("sb_tag_le", out_tag_l, e.tag);
        check("sb_valid_le", out_valid_l, 1'b1);
        popped_tags.push_back(out_tag_b);
      end
    end
    if (acc) begin
      rb = ref_load(in_data, int'(in_addr), int'(in_size), in_sext, 1'b1);
      rl = ref_load(in_data, int'(in_addr), int'(in_size), in_sext, 1'b0);
      e.tag = in_tag;
      e.err = rb[32];
      e.be  = rb[31:0];
      e.le  = rl[31:0];
      sb.push_back(e);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [31:0] d, input logic [1:0] a, input logic [1:0] sz,
                       input logic sx, input logic [4:0] tg);
    in_valid = 1'b1;
    in_data  = d;
    in_addr  = a;
    in_size  = sz;
    in_sext  = sx;
    in_tag   = tg;
  endtask

  // Single beat into an empty buffer: accepted at once, result visible exactly one cycle later.
  task automatic send_check(input string name, input logic [31:0] d, input logic [1:0] a,
                            input logic [1:0] sz, input logic sx, input logic [4:0] tg,
                            input logic exp_err, input logic [31:0] exp_be, input logic [31:0] exp_le);
    bit acc;
    out_ready = 1'b1;
    drive(d, a, sz, sx, tg);
    step(acc);
    in_valid = 1'b0;
    check({name, "_acc"}, acc, 1'b1);
    check({name, "_valid"}, out_valid_b, 1'b1);
    check({name, "_be"}, out_data_b, exp_be);
    check({name, "_le"}, out_data_l, exp_le);
    check({name, "_err"}, out_err_b, exp_err);
    check({name, "_tag"}, out_tag_b, tg);
    step(acc);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    bit acc;
    int k;
    int nacc;
    rst_n = 1'b0;
    in_valid = 1'b0;
    out_ready = 1'b0;
    in_data = '0;
    in_addr = '0;
    in_size = '0;
    in_sext = 1'b0;
    in_tag = '0;
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    check("rst_out_valid", out_valid_b, 1'b0);
    check("rst_in_ready", in_ready_b, 1'b1);
    check("rst_out_data", out_data_b, 32'h0);
    check("rst_out_tag", out_tag_b, 5'h0);
    check("rst_out_err", out_err_b, 1'b0);

    send_check("byte_a0_sx", 32'h8899AABB, 2'd0, 2'b00, 1'b1, 5'd1, 1'b0, 32'hFFFFFF88, 32'hFFFFFFBB);
    send_check("byte_a0_zx", 32'h8899AABB, 2'd0, 2'b00, 1'b0, 5'd2, 1'b0, 32'h00000088, 32'h000000BB);
    send_check("half_a2_sx", 32'h8899AABB, 2'd2, 2'b01, 1'b1, 5'd3, 1'b0, 32'hFFFFAABB, 32'hFFFF8899);
    send_check("half_a0_zx", 32'h8899AABB, 2'd0, 2'b01, 1'b0, 5'd4, 1'b0, 32'h00008899, 32'h0000AABB);
    send_check("word_a0", 32'h8899AABB, 2'd0, 2'b10, 1'b1, 5'd5, 1'b0, 32'h8899AABB, 32'h8899AABB);
    send_check("byte_a3_zx", 32'h8899AABB, 2'd3, 2'b00, 1'b0, 5'd6, 1'b0, 32'h000000BB, 32'h00000088);
    send_check("half_a1_err", 32'h8899AABB, 2'd1, 2'b01, 1'b1, 5'd7, 1'b1, 32'h0, 32'h0);
    send_check("word_a2_err", 32'h8899AABB, 2'd2, 2'b10, 1'b0, 5'd8, 1'b1, 32'h0, 32'h0);
    send_check("dword_err", 32'h8899AABB, 2'd0, 2'b11, 1'b0, 5'd9, 1'b1, 32'h0, 32'h0);

    // Backpressure: tags 1..4 offered back-to-back while out_ready is held low for 3 cycles.
    out_ready = 1'b0;
    k = 1;
    nacc = 0;
    drive($urandom, 2'($urandom), 2'($urandom), 1'($urandom), 5'(k));
    for (int c = 0; c < 3; c++) begin
      step(acc);
      if (acc) begin
        nacc++;
        k++;
        drive($urandom, 2'($urandom), 2'($urandom), 1'($urandom), 5'(k));
      end
    end
    check("bp_accepts", nacc, 2);
    check("bp_in_ready", in_ready_b, 1'b0);
    popped_tags.delete();
    out_ready = 1'b1;
    for (int c = 0; c < 20 && (k <= 4 || sb.size() > 0); c++) begin
      step(acc);
      if (acc) begin
        k++;
        if (k <= 4) drive($urandom, 2'($urandom), 2'($urandom), 1'($urandom), 5'(k));
        else in_valid = 1'b0;
      end
    end
    in_valid = 1'b0;
    check("bp_count", popped_tags.size(), 4);
    for (int i = 0; i < 4; i++) begin
      if (i < popped_tags.size()) check("bp_order", popped_tags[i], 5'(i + 1));
    end

    // Reset with both entries full must drop everything.
    out_ready = 1'b0;
    nacc = 0;
    drive(32'h12345678, 2'd0, 2'b10, 1'b0, 5'd10);
    for (int c = 0; c < 5 && nacc < 2; c++) begin
      step(acc);
      if (acc) begin
        nacc++;
        in_tag = 5'd11;
      end
    end
    in_valid = 1'b0;
    check("full_in_ready", in_ready_b, 1'b0);
    check("full_out_valid", out_valid_b, 1'b1);
    rst_n = 1'b0;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    sb.delete();
    hold_pending = 1'b0;
    check("mid_rst_out_valid", out_valid_b, 1'b0);
    check("mid_rst_in_ready", in_ready_b, 1'b1);
    check("mid_rst_out_data", out_data_b, 32'h0);
    check("mid_rst_out_err", out_err_b, 1'b0);
    send_check("post_rst_byte_a3", 32'h8899AABB, 2'd3, 2'b00, 1'b1, 5'd12, 1'b0, 32'hFFFFFFBB, 32'hFFFFFF88);

    // Random traffic with random backpressure against the reference scoreboard.
    for (int c = 0; c < 400; c++) begin
      in_valid  = ($urandom_range(0, 3) != 0);
      in_data   = $urandom;
      in_addr   = 2'($urandom);
      in_size   = 2'($urandom);
      in_sext   = 1'($urandom);
      in_tag    = 5'($urandom);
      out_ready = ($urandom_range(0, 3) != 0);
      step(acc);
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    for (int c = 0; c < 10 && sb.size() > 0; c++) step(acc);
    check("drain_empty", sb.size(), 0);
    check("drain_out_valid", out_valid_b, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/load_ext_pipe.md
Name: load_ext_pipe

Overview:
- Parametrised, pipelined load-data extender for the MEM/WB boundary.
- Takes a raw memory read word, byte offset, access size and sign-mode; selects the addressed byte, half, word or dword lane; sign- or zero-extends it to the full data width.
- Returns the result through a valid/ready handshake with a 2-entry skid buffer, so the write-back stage can stall without losing loads.
- Flags misaligned or illegal accesses.

Parameters:
- DATA_WIDTH, 32: datapath width; 32 or 64.
- BIG_ENDIAN, 1: 1 means byte offset 0 is the MSB lane (MIPS); 0 means offset 0 is the LSB lane.
- TAG_WIDTH, 5: width of the sideband tag (destination register number) carried alongside the data.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst_n  in  1  synchronous, active-low reset.
- in_valid  in  1  input beat present.
- in_ready  out  1  block can accept a beat.
- in_data  in  DATA_WIDTH  raw memory word.
- in_addr  in  OFS_W  byte offset within the word; OFS_W = log2(DATA_WIDTH/8).
- in_size  in  2  00 byte, 01 half, 10 word, 11 dword.
- in_sext  in  1  1 sign-extend, 0 zero-extend.
- in_tag  in  TAG_WIDTH  sideband, passed through unchanged.
- out_valid  out  1  result present.
- out_ready  in  1  consumer accepts the result.
- out_data  out  DATA_WIDTH  extended result.
- out_tag  out  TAG_WIDTH  tag of the result.
- out_err  out  1  misaligned or illegal access.

Behaviour:
- Reset (rst_n=0 at a clock edge):
  - both buffer entries are invalidated.
  - out_valid=0, out_data=0, out_tag=0, out_err=0, in_ready=1 from the next cycle.
  - Reset mid-stream discards any held results, with no partial output.
- Handshake:
  - A beat transfers when valid&&ready are both high at a clock edge.
  - The output is stable while out_valid=1 and out_ready=0.
- Storage: two entries, the output register (OR) and the skid register (SR).
  - in_ready = !SR_valid. It is registered, with no combinational path from out_ready.
  - Accept with OR empty, or with OR draining this cycle and SR empty: the beat goes to OR.
  - Accept while OR holds and is not draining: the beat goes to SR.
  - OR drains with SR full: SR moves to OR, and SR is freed.
  - Simultaneous accept and drain with SR empty: the new beat loads OR directly.
  - Order is strictly FIFO.
- Latency: 1 cycle from input accept to out_valid when the buffer is empty. Throughput is 1 beat per cycle while out_ready=1.
- Lane select, size n bytes at offset a:
  - BIG_ENDIAN=1: field = in_data[DATA_WIDTH-1-8a -: 8n].
  - BIG_ENDIAN=0: field = in_data[8a+8n-1 : 8a].
- Extension:
  - Upper DATA_WIDTH-8n bits = field MSB when in_sext=1, else 0.
  - Size equal to DATA_WIDTH passes the field through; in_sext is ignored.
- Error cases set out_err=1, out_data=0, and still propagate the tag:
  - half with a[0]=1.
  - word with a[1:0]!=0.
  - dword with a!=0.
  - dword when DATA_WIDTH=32.
- Extension is computed before the register. out_data is a pure register output.

Test Plan:
- DATA_WIDTH=32, BIG_ENDIAN=1, in_data=0x8899AABB, byte, a=0, sext=1 -> out_data=0xFFFFFF88 one cycle later. With sext=0 -> 0x00000088.
- Same data, half, a=2, sext=1 -> 0xFFFFAABB. Half, a=0, sext=0 -> 0x00008899. Word, a=0 -> 0x8899AABB.
- BIG_ENDIAN=0, in_data=0x8899AABB, byte, a=0, sext=1 -> 0xFFFFFFBB. Byte, a=3, sext=0 -> 0x00000088.
- Half with a=1, tag=7 -> out_err=1, out_data=0, out_tag=7. Dword on DATA_WIDTH=32 -> out_err=1.
- Backpressure stream, tags 1..4 back-to-back, out_ready=0 for 3 cycles:
  - in_ready drops after 2 accepts.
  - Then out_ready=1 -> tags 1,2,3,4 emerge in order, none lost or duplicated.
- rst_n=0 for one edge while both entries are full -> next cycle out_valid=0, in_ready=1, out_data=0. A new beat then yields a correct result after 1 cycle.
